// File: rtl/instruction_data_memory_arbiter_if.sv
// instruction_data_memory_arbiter_if: requester-side and memory-side signals of the shared memory port
interface instruction_data_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    inst_enable;
  logic [ADDR_WIDTH-1:0]   inst_addr;
  logic                    inst_busy;
  logic [DATA_WIDTH-1:0]   inst_rd_data;
  logic                    data_rd_enable;
  logic                    data_wr_enable;
  logic [ADDR_WIDTH-1:0]   data_addr;
  logic [DATA_WIDTH-1:0]   data_wr_data;
  logic [DATA_WIDTH/8-1:0] data_byte_en;
  logic                    data_busy;
  logic [DATA_WIDTH-1:0]   data_rd_data;
  logic                    mem_rd_enable;
  logic                    mem_wr_enable;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wr_data;
  logic [DATA_WIDTH/8-1:0] mem_byte_en;
  logic                    mem_busy;
  logic [DATA_WIDTH-1:0]   mem_rd_data;
  modport slave (
    input  inst_enable, inst_addr, data_rd_enable, data_wr_enable, data_addr,
           data_wr_data, data_byte_en, mem_busy, mem_rd_data,
    output inst_busy, inst_rd_data, data_busy, data_rd_data, mem_rd_enable,
           mem_wr_enable, mem_addr, mem_wr_data, mem_byte_en
  );
  modport master (
    output inst_enable, inst_addr, data_rd_enable, data_wr_enable, data_addr,
           data_wr_data, data_byte_en, mem_busy, mem_rd_data,
    input  inst_busy, inst_rd_data, data_busy, data_rd_data, mem_rd_enable,
           mem_wr_enable, mem_addr, mem_wr_data, mem_byte_en
  );
endinterface

// File: rtl/instruction_data_memory_arbiter.sv
// instruction_data_memory_arbiter: shares one memory port between instruction fetch and CPU data requests
module instruction_data_memory_arbiter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input logic clock,
  input logic reset,
  instruction_data_memory_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GNT_INST = 2'd1;
  localparam logic [1:0] GNT_DATA = 2'd2;
  logic [1:0]              state;
  logic [1:0]              state_next;
  logic [1:0]              pick;
  logic                    last_grant;
  logic                    data_req;
  logic                    inst_gnt;
  logic                    data_gnt;
  logic                    leave;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [DATA_WIDTH/8-1:0] all_bytes;
  assign data_req  = bus.data_rd_enable | bus.data_wr_enable;
  assign inst_gnt  = state == GNT_INST;
  assign data_gnt  = state == GNT_DATA;
  assign all_bytes = '1;
  // Busy is combinational so a requester sees it in the very cycle it raises its request
  assign bus.inst_busy = bus.inst_enable & ~(inst_gnt & ~bus.mem_busy);
  assign bus.data_busy = data_req & ~(data_gnt & ~bus.mem_busy);
  // Read data goes to both sides; only the granted requester's completion cycle is meaningful
  assign bus.inst_rd_data = bus.mem_rd_data;
  assign bus.data_rd_data = bus.mem_rd_data;
  // Write beats read when the data side raises both; enables follow the request so an abort drops them at once
  assign bus.mem_rd_enable = inst_gnt ? bus.inst_enable : data_gnt & bus.data_rd_enable & ~bus.data_wr_enable;
  assign bus.mem_wr_enable = data_gnt & bus.data_wr_enable;
  assign addr_sel          = inst_gnt ? bus.inst_addr : data_gnt ? bus.data_addr : '0;
  assign bus.mem_addr      = addr_sel;
  assign bus.mem_wr_data   = data_gnt ? bus.data_wr_data : '0;
  assign bus.mem_byte_en   = inst_gnt ? all_bytes : data_gnt ? bus.data_byte_en : '0;
  // A grant ends on completion or when the granted request is withdrawn
  assign leave = (inst_gnt & (~bus.inst_enable | ~bus.mem_busy)) |
                 (data_gnt & (~data_req | ~bus.mem_busy));
  // On contention, round-robin favours the side not served last; otherwise data always wins
  assign pick = (bus.inst_enable & data_req) ? ((ROUND_ROBIN && last_grant) ? GNT_INST : GNT_DATA) :
                bus.inst_enable ? GNT_INST : data_req ? GNT_DATA : IDLE;
  assign state_next = (state == IDLE) ? pick : (leave | ~(inst_gnt | data_gnt)) ? IDLE : state;
  // Grant state and last-served side; last_grant=1 means data, so the first contention goes to inst
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (leave) last_grant <= data_gnt;
    end
  end
endmodule

// File: tb/tb_instruction_data_memory_arbiter.sv
// tb_instruction_data_memory_arbiter: directed checks of grant order, timing, abort and reset behaviour
module tb_instruction_data_memory_arbiter;
  localparam logic [63:0] K = 64'h5A5A_0000_C3C3_0000;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   wait_n = 0;
  int   cnt_rr = 0;
  int   cnt_fp = 0;
  instruction_data_memory_arbiter_if bus_rr ();
  instruction_data_memory_arbiter_if bus_fp ();
  instruction_data_memory_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (.clock(clock), .reset(reset), .bus(bus_rr));
  instruction_data_memory_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (.clock(clock), .reset(reset), .bus(bus_fp));
  always #5 clock = ~clock;
  // memory model: stays busy for wait_n cycles of a held enable, read data is address ^ K
  assign bus_rr.mem_busy    = (bus_rr.mem_rd_enable | bus_rr.mem_wr_enable) && (cnt_rr < wait_n);
  assign bus_rr.mem_rd_data = bus_rr.mem_addr ^ K;
  assign bus_fp.mem_busy    = (bus_fp.mem_rd_enable | bus_fp.mem_wr_enable) && (cnt_fp < wait_n);
  assign bus_fp.mem_rd_data = bus_fp.mem_addr ^ K;
  always @(posedge clock) begin
    cnt_rr <= ((bus_rr.mem_rd_enable | bus_rr.mem_wr_enable) && bus_rr.mem_busy) ? cnt_rr + 1 : 0;
    cnt_fp <= ((bus_fp.mem_rd_enable | bus_fp.mem_wr_enable) && bus_fp.mem_busy) ? cnt_fp + 1 : 0;
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic clear_inputs();
    bus_rr.inst_enable = 0; bus_rr.inst_addr = 0; bus_rr.data_rd_enable = 0; bus_rr.data_wr_enable = 0;
    bus_rr.data_addr = 0; bus_rr.data_wr_data = 0; bus_rr.data_byte_en = 0;
    bus_fp.inst_enable = 0; bus_fp.inst_addr = 0; bus_fp.data_rd_enable = 0; bus_fp.data_wr_enable = 0;
    bus_fp.data_addr = 0; bus_fp.data_wr_data = 0; bus_fp.data_byte_en = 0;
  endtask
  task automatic test_reset();
    clear_inputs();
    step();
    tests++;
    if ({bus_rr.mem_rd_enable, bus_rr.mem_wr_enable, bus_rr.inst_busy, bus_rr.data_busy} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 0000", {bus_rr.mem_rd_enable, bus_rr.mem_wr_enable, bus_rr.inst_busy, bus_rr.data_busy});
    end
    tests++;
    if ({bus_rr.mem_addr, bus_rr.mem_wr_data, bus_rr.mem_byte_en} !== 136'd0) begin
      fails++;
      $display("FAIL reset_bus got %h exp 0", {bus_rr.mem_addr, bus_rr.mem_wr_data, bus_rr.mem_byte_en});
    end
    bus_rr.inst_enable = 1;
    #1;
    tests++;
    if ({bus_rr.inst_busy, bus_rr.mem_rd_enable} !== 2'b10) begin
      fails++;
      $display("FAIL reset_busy_follow got %b exp 10", {bus_rr.inst_busy, bus_rr.mem_rd_enable});
    end
    bus_rr.inst_enable = 0;
    step();
    reset = 0;
    step();
  endtask
  task automatic test_single_fetch();
    wait_n = 2;
    bus_rr.inst_enable = 1; bus_rr.inst_addr = 64'h1000;
    #1;
    tests++;
    if ({bus_rr.inst_busy, bus_rr.mem_rd_enable} !== 2'b10) begin
      fails++;
      $display("FAIL fetch_c0 got %b exp 10", {bus_rr.inst_busy, bus_rr.mem_rd_enable});
    end
    step();
    tests++;
    if ({bus_rr.mem_rd_enable, bus_rr.mem_wr_enable, bus_rr.inst_busy} !== 3'b101 ||
        bus_rr.mem_addr !== 64'h1000 || bus_rr.mem_byte_en !== 8'hFF) begin
      fails++;
      $display("FAIL fetch_c1 got %b addr %h be %h exp 101 addr 1000 be ff",
               {bus_rr.mem_rd_enable, bus_rr.mem_wr_enable, bus_rr.inst_busy}, bus_rr.mem_addr, bus_rr.mem_byte_en);
    end
    step();
    tests++;
    if ({bus_rr.mem_rd_enable, bus_rr.inst_busy} !== 2'b11) begin
      fails++;
      $display("FAIL fetch_c2 got %b exp 11", {bus_rr.mem_rd_enable, bus_rr.inst_busy});
    end
    step();
    tests++;
    if (bus_rr.inst_busy !== 1'b0 || bus_rr.inst_rd_data !== (64'h1000 ^ K)) begin
      fails++;
      $display("FAIL fetch_done got busy %b data %h exp busy 0 data %h", bus_rr.inst_busy, bus_rr.inst_rd_data, 64'h1000 ^ K);
    end
    bus_rr.inst_enable = 0;
    step();
    tests++;
    if ({bus_rr.mem_rd_enable, bus_rr.inst_busy} !== 2'b00 || bus_rr.mem_addr !== 64'h0) begin
      fails++;
      $display("FAIL fetch_idle got %b addr %h exp 00 addr 0", {bus_rr.mem_rd_enable, bus_rr.inst_busy}, bus_rr.mem_addr);
    end
  endtask
  task automatic test_data_write();
    wait_n = 0;
    bus_rr.data_wr_enable = 1; bus_rr.data_addr = 64'h20; bus_rr.data_wr_data = 64'hDEADBEEF; bus_rr.data_byte_en = 8'h0F;
    step();
    tests++;
    if ({bus_rr.mem_wr_enable, bus_rr.mem_rd_enable, bus_rr.data_busy} !== 3'b100 || bus_rr.mem_addr !== 64'h20 ||
        bus_rr.mem_wr_data !== 64'hDEADBEEF || bus_rr.mem_byte_en !== 8'h0F) begin
      fails++;
      $display("FAIL write_c1 got %b addr %h wd %h be %h exp 100 addr 20 wd deadbeef be 0f",
               {bus_rr.mem_wr_enable, bus_rr.mem_rd_enable, bus_rr.data_busy}, bus_rr.mem_addr, bus_rr.mem_wr_data, bus_rr.mem_byte_en);
    end
    bus_rr.data_wr_enable = 0;
    step();
    tests++;
    if ({bus_rr.mem_wr_enable, bus_rr.mem_wr_data, bus_rr.mem_byte_en} !== 73'd0) begin
      fails++;
      $display("FAIL write_idle got %h exp 0", {bus_rr.mem_wr_enable, bus_rr.mem_wr_data, bus_rr.mem_byte_en});
    end
  endtask
  task automatic test_rd_wr_conflict();
    wait_n = 0;
    bus_rr.data_rd_enable = 1; bus_rr.data_wr_enable = 1; bus_rr.data_addr = 64'h40; bus_rr.data_wr_data = 64'h1234; bus_rr.data_byte_en = 8'hFF;
    step();
    tests++;
    if ({bus_rr.mem_wr_enable, bus_rr.mem_rd_enable, bus_rr.data_busy} !== 3'b100) begin
      fails++;
      $display("FAIL conflict got %b exp 100", {bus_rr.mem_wr_enable, bus_rr.mem_rd_enable, bus_rr.data_busy});
    end
    bus_rr.data_rd_enable = 0; bus_rr.data_wr_enable = 0;
    step();
  endtask
  task automatic test_round_robin();
    wait_n = 1;
    bus_rr.inst_enable = 1; bus_rr.inst_addr = 64'h100;
    bus_rr.data_rd_enable = 1; bus_rr.data_addr = 64'h200;
    for (int g = 0; g < 4; g++) begin
      logic is_inst;
      logic [63:0] a;
      is_inst = (g % 2) == 0;
      a = is_inst ? 64'h100 : 64'h200;
      step();
      tests++;
      if (bus_rr.mem_rd_enable !== 1'b1 || bus_rr.mem_addr !== a || {bus_rr.inst_busy, bus_rr.data_busy} !== 2'b11) begin
        fails++;
        $display("FAIL rr_grant%0d got rd %b addr %h busy %b exp rd 1 addr %h busy 11",
                 g, bus_rr.mem_rd_enable, bus_rr.mem_addr, {bus_rr.inst_busy, bus_rr.data_busy}, a);
      end
      step();
      tests++;
      if ({bus_rr.inst_busy, bus_rr.data_busy} !== (is_inst ? 2'b01 : 2'b10) || bus_rr.data_rd_data !== (a ^ K)) begin
        fails++;
        $display("FAIL rr_done%0d got busy %b data %h exp busy %b data %h",
                 g, {bus_rr.inst_busy, bus_rr.data_busy}, bus_rr.data_rd_data, is_inst ? 2'b01 : 2'b10, a ^ K);
      end
      step();
      tests++;
      if ({bus_rr.mem_rd_enable, bus_rr.inst_busy, bus_rr.data_busy} !== 3'b011) begin
        fails++;
        $display("FAIL rr_idle%0d got %b exp 011", g, {bus_rr.mem_rd_enable, bus_rr.inst_busy, bus_rr.data_busy});
      end
    end
    bus_rr.inst_enable = 0; bus_rr.data_rd_enable = 0;
    step();
  endtask
  task automatic test_abort();
    wait_n = 10;
    bus_rr.inst_enable = 1; bus_rr.inst_addr = 64'h300;
    bus_rr.data_rd_enable = 1; bus_rr.data_addr = 64'h400;
    step();
    tests++;
    if (bus_rr.mem_rd_enable !== 1'b1 || bus_rr.mem_addr !== 64'h300) begin
      fails++;
      $display("FAIL abort_grant got rd %b addr %h exp rd 1 addr 300", bus_rr.mem_rd_enable, bus_rr.mem_addr);
    end
    step();
    bus_rr.inst_enable = 0;
    #1;
    tests++;
    if ({bus_rr.mem_rd_enable, bus_rr.inst_busy, bus_rr.data_busy} !== 3'b001) begin
      fails++;
      $display("FAIL abort_drop got %b exp 001", {bus_rr.mem_rd_enable, bus_rr.inst_busy, bus_rr.data_busy});
    end
    step();
    tests++;
    if (bus_rr.mem_rd_enable !== 1'b0 || bus_rr.mem_addr !== 64'h0) begin
      fails++;
      $display("FAIL abort_idle got rd %b addr %h exp rd 0 addr 0", bus_rr.mem_rd_enable, bus_rr.mem_addr);
    end
    step();
    tests++;
    if (bus_rr.mem_rd_enable !== 1'b1 || bus_rr.mem_addr !== 64'h400) begin
      fails++;
      $display("FAIL abort_next got rd %b addr %h exp rd 1 addr 400", bus_rr.mem_rd_enable, bus_rr.mem_addr);
    end
    bus_rr.data_rd_enable = 0;
    step();
  endtask
  task automatic test_reset_mid();
    wait_n = 10;
    bus_rr.data_rd_enable = 1; bus_rr.data_addr = 64'h500;
    step();
    tests++;
    if (bus_rr.mem_rd_enable !== 1'b1 || bus_rr.mem_addr !== 64'h500) begin
      fails++;
      $display("FAIL rstmid_grant got rd %b addr %h exp rd 1 addr 500", bus_rr.mem_rd_enable, bus_rr.mem_addr);
    end
    bus_rr.inst_enable = 1; bus_rr.inst_addr = 64'h600;
    reset = 1;
    #1;
    tests++;
    if ({bus_rr.mem_rd_enable, bus_rr.mem_wr_enable, bus_rr.inst_busy, bus_rr.data_busy} !== 4'b0011 || bus_rr.mem_addr !== 64'h0) begin
      fails++;
      $display("FAIL rstmid_drop got %b addr %h exp 0011 addr 0",
               {bus_rr.mem_rd_enable, bus_rr.mem_wr_enable, bus_rr.inst_busy, bus_rr.data_busy}, bus_rr.mem_addr);
    end
    step();
    reset = 0;
    step();
    tests++;
    if (bus_rr.mem_rd_enable !== 1'b1 || bus_rr.mem_addr !== 64'h600) begin
      fails++;
      $display("FAIL rstmid_regrant got rd %b addr %h exp rd 1 addr 600", bus_rr.mem_rd_enable, bus_rr.mem_addr);
    end
    bus_rr.inst_enable = 0; bus_rr.data_rd_enable = 0;
    step();
  endtask
  task automatic test_fixed_priority();
    wait_n = 1;
    bus_fp.inst_enable = 1; bus_fp.inst_addr = 64'h700;
    bus_fp.data_rd_enable = 1; bus_fp.data_addr = 64'h800;
    for (int g = 0; g < 2; g++) begin
      step();
      tests++;
      if (bus_fp.mem_rd_enable !== 1'b1 || bus_fp.mem_addr !== 64'h800 || {bus_fp.inst_busy, bus_fp.data_busy} !== 2'b11) begin
        fails++;
        $display("FAIL fp_grant%0d got rd %b addr %h busy %b exp rd 1 addr 800 busy 11",
                 g, bus_fp.mem_rd_enable, bus_fp.mem_addr, {bus_fp.inst_busy, bus_fp.data_busy});
      end
      step();
      tests++;
      if ({bus_fp.inst_busy, bus_fp.data_busy} !== 2'b10) begin
        fails++;
        $display("FAIL fp_done%0d got %b exp 10", g, {bus_fp.inst_busy, bus_fp.data_busy});
      end
      if (g == 0) step();
    end
    bus_fp.data_rd_enable = 0;
    step();
    tests++;
    if (bus_fp.mem_rd_enable !== 1'b0 || bus_fp.inst_busy !== 1'b1) begin
      fails++;
      $display("FAIL fp_idle got rd %b busy %b exp rd 0 busy 1", bus_fp.mem_rd_enable, bus_fp.inst_busy);
    end
    step();
    tests++;
    if (bus_fp.mem_rd_enable !== 1'b1 || bus_fp.mem_addr !== 64'h700) begin
      fails++;
      $display("FAIL fp_inst got rd %b addr %h exp rd 1 addr 700", bus_fp.mem_rd_enable, bus_fp.mem_addr);
    end
    step();
    tests++;
    if (bus_fp.inst_busy !== 1'b0 || bus_fp.inst_rd_data !== (64'h700 ^ K)) begin
      fails++;
      $display("FAIL fp_inst_done got busy %b data %h exp busy 0 data %h", bus_fp.inst_busy, bus_fp.inst_rd_data, 64'h700 ^ K);
    end
    bus_fp.inst_enable = 0;
    step();
  endtask
  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_rd_wr_conflict();
    test_round_robin();
    test_abort();
    test_reset_mid();
    test_fixed_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
